// File: rtl/tpu_spi_slave.sv
// tpu_spi_slave: SPI mode-0 slave that converts two-byte host frames
// (command byte + data byte) into single-cycle register-bus accesses.
// All SPI pins are resynchronized into clk before use.
// Optional build macro: SPI_ERR_STATUS_EN -- when defined, MISO returns a
// status byte {5'b0, last_abort, last_rejected, last_ok} for the previous
// frame while the host shifts in the command byte.
module tpu_spi_slave (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_sclk,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic [3:0] reg_addr,
  output logic       reg_rd,
  output logic       reg_wr,
  output logic [7:0] reg_wdata,
  input  logic [7:0] reg_rdata,
  input  logic       reg_addr_valid,
  input  logic       reg_writable,
  output logic       frame_err
);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_DONE} state_t;

  state_t     state_q, state_d;

  // Synchronizer chains; the third SCLK/CS stage is the edge-detect history.
  logic [2:0] sclk_q;
  logic [2:0] cs_q;
  logic [1:0] mosi_q;

  logic [4:0] bit_cnt_q;
  logic [7:0] rx_q;
  logic [7:0] tx_q;
  logic       cmd_wr_q;
  logic       cmd_aligned_q;
  logic [3:0] reg_addr_q;
  logic       entry_q;
  logic       addr_ok_q;
  logic       writable_q;
  logic       reg_wr_q;
  logic [7:0] reg_wdata_q;
  logic       wr_err_q;

  logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_s;
  logic shifting, entry_live, addr_ok_c;

  assign sclk_rise  = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall  = ~sclk_q[1] & sclk_q[2];
  assign cs_fall    = ~cs_q[1] & cs_q[2];
  assign cs_rise    = cs_q[1] & ~cs_q[2];
  assign mosi_s     = mosi_q[1];
  assign shifting   = (state_q == S_CMD) || (state_q == S_DATA);
  // First DATA cycle: reg_addr has just settled, so the register file's
  // combinational valid flag now refers to this frame's address.
  assign entry_live = entry_q && (state_q == S_DATA) && !cs_rise;
  assign addr_ok_c  = cmd_aligned_q & reg_addr_valid;

  assign reg_addr  = reg_addr_q;
  assign reg_wr    = reg_wr_q;
  assign reg_wdata = reg_wdata_q;

  // Two-flop synchronizers plus one history flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q <= 3'b000;
      cs_q   <= 3'b111;
      mosi_q <= 2'b00;
    end else begin
      sclk_q <= {sclk_q[1:0], spi_sclk};
      cs_q   <= {cs_q[1:0], spi_cs_n};
      mosi_q <= {mosi_q[0], spi_mosi};
    end
  end

  // Frame FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Frame FSM next-state logic; CS rising always returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (cs_fall) state_d = S_CMD;
      S_CMD: begin
        if (cs_rise)                               state_d = S_IDLE;
        else if (sclk_rise && bit_cnt_q == 5'd7)   state_d = S_DATA;
      end
      S_DATA: begin
        if (cs_rise)                               state_d = S_IDLE;
        else if (sclk_rise && bit_cnt_q == 5'd15)  state_d = S_DONE;
      end
      S_DONE: if (cs_rise) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

`ifdef SPI_ERR_STATUS_EN
  logic [2:0] status_q;
  logic [7:0] stat_sh_q;
  logic       frame_rej_q;

  // Previous-frame status: recorded at every frame end, shifted out during CMD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q    <= 3'b000;
      stat_sh_q   <= 8'h00;
      frame_rej_q <= 1'b0;
    end else begin
      if (state_q == S_IDLE && cs_fall) begin
        stat_sh_q   <= {5'b00000, status_q};
        frame_rej_q <= 1'b0;
      end else begin
        if (state_q == S_CMD && sclk_fall) stat_sh_q <= {stat_sh_q[6:0], 1'b0};
        if (frame_err) frame_rej_q <= 1'b1;
      end
      if (cs_rise) begin
        if (state_q == S_DONE)  status_q <= {1'b0, frame_rej_q, ~frame_rej_q};
        else if (shifting)      status_q <= 3'b100;
      end
    end
  end
`endif

  // Frame FSM outputs: read strobe, rejection pulse and MISO selection.
  always_comb begin
    reg_rd    = 1'b0;
    frame_err = wr_err_q;
    spi_miso  = 1'b0;
    if (entry_live && !cmd_wr_q) begin
      if (addr_ok_c) reg_rd    = 1'b1;
      else           frame_err = 1'b1;
    end
    case (state_q)
      S_DATA: spi_miso = tx_q[7];
`ifdef SPI_ERR_STATUS_EN
      S_CMD:  spi_miso = stat_sh_q[7];
`else
      S_CMD:  spi_miso = 1'b0;
`endif
      default: spi_miso = 1'b0;
    endcase
  end

  // Shift registers, command decode and register-bus write generation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q     <= 5'd0;
      rx_q          <= 8'h00;
      tx_q          <= 8'h00;
      cmd_wr_q      <= 1'b0;
      cmd_aligned_q <= 1'b0;
      reg_addr_q    <= 4'd0;
      entry_q       <= 1'b0;
      addr_ok_q     <= 1'b0;
      writable_q    <= 1'b0;
      reg_wr_q      <= 1'b0;
      reg_wdata_q   <= 8'h00;
      wr_err_q      <= 1'b0;
    end else begin
      reg_wr_q <= 1'b0;
      wr_err_q <= 1'b0;
      entry_q  <= (state_q == S_CMD) && (state_d == S_DATA);

      if (state_q == S_IDLE && cs_fall) begin
        bit_cnt_q <= 5'd0;
        tx_q      <= 8'h00;
      end

      if (shifting && sclk_rise && !cs_rise) begin
        bit_cnt_q <= bit_cnt_q + 5'd1;
        rx_q      <= {rx_q[6:0], mosi_s};
      end

      // 8th rise: command byte complete = {rx_q[6:0], mosi_s}.
      if (state_q == S_CMD && state_d == S_DATA) begin
        cmd_wr_q      <= rx_q[6];
        cmd_aligned_q <= ~rx_q[5] & ~rx_q[0] & ~mosi_s;
        reg_addr_q    <= rx_q[4:1];
      end

      if (entry_live) begin
        addr_ok_q  <= addr_ok_c;
        writable_q <= reg_writable;
        tx_q       <= (!cmd_wr_q && addr_ok_c) ? reg_rdata : 8'h00;
      end else if (state_q == S_DATA && sclk_fall && bit_cnt_q != 5'd8) begin
        // The fall right after bit 8 keeps bit7 of the loaded byte on MISO.
        tx_q <= {tx_q[6:0], 1'b0};
      end

      // 16th rise: commit or reject the write.
      if (state_q == S_DATA && state_d == S_DONE && cmd_wr_q) begin
        if (addr_ok_q && writable_q) begin
          reg_wr_q    <= 1'b1;
          reg_wdata_q <= {rx_q[6:0], mosi_s};
        end else begin
          wr_err_q <= 1'b1;
        end
      end
    end
  end

endmodule
